// File: rtl/adventure_game_ext_pkg.sv
// Shared room indices, one-hot room encoding and direction codes
// for the adventure game FSM and its input decoder.
package adventure_pkg;

  localparam int CAVE      = 0;
  localparam int TUNNEL    = 1;
  localparam int RIVER     = 2;
  localparam int STASH     = 3;
  localparam int DEN       = 4;
  localparam int VAULT     = 5;
  localparam int GRAVE     = 6;
  localparam int NUM_ROOMS = 7;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  // One-hot so the state register drives the room LEDs directly
  typedef enum logic [NUM_ROOMS-1:0] {
    ST_CAVE   = 7'b0000001,
    ST_TUNNEL = 7'b0000010,
    ST_RIVER  = 7'b0000100,
    ST_STASH  = 7'b0001000,
    ST_DEN    = 7'b0010000,
    ST_VAULT  = 7'b0100000,
    ST_GRAVE  = 7'b1000000
  } room_t;

endpackage

// File: rtl/adventure_game_ext_dir_decoder.sv
// Turns the four button lines into a single validated direction command;
// ambiguous presses are dropped and, in edge mode, held keys fire once.
module dir_decoder
  import adventure_pkg::*;
#(
  parameter int EDGE_MODE = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_n,
  input  logic i_e,
  input  logic i_s,
  input  logic i_w,
  output logic o_valid,
  output dir_t o_dir
);

  logic [3:0] w_keys;
  logic [3:0] r_prev;
  logic       w_onehot;
  logic       w_fresh;

  assign w_keys = {i_w, i_s, i_e, i_n};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= '0;
    else       r_prev <= w_keys;
  end

  always_comb begin
    o_dir    = DIR_N;
    w_onehot = 1'b0;
    case (w_keys)
      4'b0001: begin o_dir = DIR_N; w_onehot = 1'b1; end
      4'b0010: begin o_dir = DIR_E; w_onehot = 1'b1; end
      4'b0100: begin o_dir = DIR_S; w_onehot = 1'b1; end
      4'b1000: begin o_dir = DIR_W; w_onehot = 1'b1; end
      default: ;
    endcase
  end

  // With a single key high, it is fresh iff it was low last cycle
  assign w_fresh = |(w_keys & ~r_prev);
  assign o_valid = w_onehot && ((EDGE_MODE == 0) || w_fresh);

endmodule

// File: rtl/adventure_game_ext.sv
// Seven-room adventure FSM with lives/respawn, optional move budget,
// saturating move counter and Moore win/die indicators.
module adventure_game_ext
  import adventure_pkg::*;
#(
  parameter int LIVES      = 1,
  parameter int MOVE_LIMIT = 0,
  parameter int MOVE_W     = 8,
  parameter int EDGE_MODE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              e,
  input  logic              s,
  input  logic              w,
  output logic [6:0]        room,
  output logic              win,
  output logic              die,
  output logic              sword,
  output logic [3:0]        lives_left,
  output logic [MOVE_W-1:0] moves,
  output logic              lost_life
);

  localparam logic [MOVE_W-1:0] LIMIT      = MOVE_W'(MOVE_LIMIT);
  localparam logic [3:0]        LIVES_INIT = 4'(LIVES);

  room_t             r_room, w_room_next, w_dest;
  logic              r_sword, w_sword_next;
  logic [3:0]        r_lives, w_lives_next;
  logic [MOVE_W-1:0] r_moves, w_moves_next;
  logic              r_lost, w_lost_next;
  logic              w_cmd_valid;
  dir_t              w_cmd_dir;

  dir_decoder #(.EDGE_MODE(EDGE_MODE)) u_dir (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_n     (n),
    .i_e     (e),
    .i_s     (s),
    .i_w     (w),
    .o_valid (w_cmd_valid),
    .o_dir   (w_cmd_dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_room  <= ST_CAVE;
      r_sword <= 1'b0;
      r_lives <= LIVES_INIT;
      r_moves <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_room  <= w_room_next;
      r_sword <= w_sword_next;
      r_lives <= w_lives_next;
      r_moves <= w_moves_next;
      r_lost  <= w_lost_next;
    end
  end

  // Map lookup: destination equals the current room when a wall is hit
  always_comb begin
    w_dest = r_room;
    if (w_cmd_valid) begin
      case (r_room)
        ST_CAVE:   if (w_cmd_dir == DIR_E) w_dest = ST_TUNNEL;
        ST_TUNNEL: begin
          if (w_cmd_dir == DIR_S)      w_dest = ST_RIVER;
          else if (w_cmd_dir == DIR_W) w_dest = ST_CAVE;
        end
        ST_RIVER: begin
          if (w_cmd_dir == DIR_N)      w_dest = ST_TUNNEL;
          else if (w_cmd_dir == DIR_W) w_dest = ST_STASH;
          else if (w_cmd_dir == DIR_E) w_dest = ST_DEN;
        end
        ST_STASH:  if (w_cmd_dir == DIR_E) w_dest = ST_RIVER;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_room_next  = r_room;
    w_sword_next = r_sword;
    w_lives_next = r_lives;
    w_moves_next = r_moves;
    w_lost_next  = 1'b0;
    case (r_room)
      ST_CAVE, ST_TUNNEL, ST_RIVER, ST_STASH: begin
        if ((MOVE_LIMIT != 0) && (r_moves == LIMIT)) begin
          w_room_next = ST_GRAVE;
        end else if (w_dest != r_room) begin
          w_room_next = w_dest;
          if (r_moves != '1) w_moves_next = r_moves + MOVE_W'(1);
          if (w_dest == ST_STASH) w_sword_next = 1'b1;
        end
      end
      ST_DEN:   w_room_next = r_sword ? ST_VAULT : ST_GRAVE;
      ST_VAULT: w_room_next = ST_VAULT;
      ST_GRAVE: begin
        // Last life makes the graveyard absorbing
        if (r_lives > 4'd1) begin
          w_room_next  = ST_CAVE;
          w_lives_next = r_lives - 4'd1;
          w_sword_next = 1'b0;
          w_moves_next = '0;
          w_lost_next  = 1'b1;
        end
      end
      default:  w_room_next = ST_CAVE;
    endcase
  end

  assign room       = r_room;
  assign win        = r_room[VAULT];
  assign die        = r_room[GRAVE] && (r_lives == 4'd1);
  assign sword      = r_sword;
  assign lives_left = r_lives;
  assign moves      = r_moves;
  assign lost_life  = r_lost;

endmodule

// File: doc/adventure_game_ext.md
# adventure_game_ext

Parametrised next-generation adventure-game FSM: same seven-room map, driven by one-cycle n/e/s/w commands, with Moore win/die outputs. Adds a lives counter with respawn, an optional move limit, an optional edge-triggered command mode, and rejection of ambiguous multi-direction inputs. It sits directly under the board top, fed by debounced push-buttons, and drives room LEDs plus win/die indicators.

## Interface
- LIVES, 1: lives at reset, range 1..15.
- MOVE_LIMIT, 0: accepted-move budget; 0 disables the limit; range 0..2^MOVE_W-1.
- MOVE_W, 8: width of the move counter.
- EDGE_MODE, 0: 0 = level (a held key moves every cycle); 1 = a move only on a key's 0->1 transition.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- n, e, s, w  in  1 each  direction commands, synchronous to clk.
- room  out  7  one-hot current room: [0] Cave of Cacophony, [1] Twisty Tunnel, [2] Rapid River, [3] Secret Sword Stash, [4] Dragon's Den, [5] Victory Vault, [6] Grievous Graveyard.
- win  out  1  room[5].
- die  out  1  room[6] with no lives remaining (terminal death).
- sword  out  1  sword held.
- lives_left  out  4  remaining lives.
- moves  out  MOVE_W  accepted-move count, saturating.
- lost_life  out  1  one-cycle pulse when a non-final life is lost.

## Operation
- Command: exactly one of n/e/s/w valid this cycle; zero or ≥2 high → no command. EDGE_MODE=1: that key must also have been low last cycle (its previous-value register is cleared by reset).
- Map, command → next room: Cave: e→Tunnel. Tunnel: s→River, w→Cave. River: n→Tunnel, w→Stash, e→Den. Stash: e→River.
- Any other command in these rooms hits a wall: room unchanged, moves unchanged.
- Accepted move (a real room change from rooms 0-3): moves += 1, saturating at all-ones.
- Stash: sword set on the cycle the room is entered. Sword stays set until respawn or reset.
- Den: ignores inputs. Next cycle goes to Vault if sword=1, else to Graveyard.
- Move limit: if MOVE_LIMIT≠0 and, in rooms 0-3, moves == MOVE_LIMIT, next room is Graveyard regardless of command.
- Vault: absorbing; win=1 until reset.
- Graveyard with lives_left>1: stay exactly one cycle (die=0), then go to Cave. On that transition: lives_left -= 1, sword cleared, moves cleared, lost_life=1 for one cycle.
- Graveyard with lives_left==1: absorbing; die=1 until reset; lives_left stays 1.
- Reset values: room=0000001 (Cave), sword=0, lives_left=LIVES, moves=0, lost_life=0, win=0, die=0.

## Timing
- Inputs are sampled on a rising edge; room, sword, moves and lives update on the same edge.
- win and die are decoded from registered state, so they follow room with no added latency.
- Den→Vault/Graveyard: one cycle after entering Den.
- Respawn: Graveyard is held 1 cycle. lost_life is asserted in the same cycle Cave is first shown.
- Move limit is checked on the current moves value. Example: MOVE_LIMIT=2 means the cycle after the 2nd accepted move goes to Graveyard.
- Reset is asynchronous: outputs reach their reset values without waiting for a clock edge, in any state. The first move is possible on the first edge after deassertion.

## Structure
- Package adventure_pkg: room index localparams (CAVE=0 … GRAVE=6), NUM_ROOMS=7, direction encoding.
- Sub-module dir_decoder: previous-input registers, EDGE_MODE gating, exactly-one check. Outputs a valid flag and a 2-bit direction.
- Top holds: room register (one-hot), sword flag, lives counter, moves counter, and next-state logic.

## Test plan
- Win path, defaults: reset; then e, s, w, e, e, idle → room sequence 0000001, 0000010, 0000100, 0001000 (sword=1), 0000100, 0010000, 0100000. win=1 persists, moves=5.
- No sword: e, s, e → Den, then Graveyard next cycle. die=1 held for 10 idle cycles; inputs ignored.
- LIVES=3: die twice. Each death gives one Graveyard cycle, then Cave with lost_life pulse, lives_left 3→2→1, sword=0, moves=0. Third death → die=1, lives_left=1.
- Ambiguous and wall inputs: in Cave, n=e=1 → no move. In Cave, w=1 → stays in Cave, moves=0.
- EDGE_MODE=1: in Cave, e held 3 cycles → one move to Tunnel only. Release then s pulse → River.
- MOVE_LIMIT=2: e, w, then idle → Graveyard on the cycle after moves==2. Assert reset mid-move → Cave immediately, all counters at reset values.
